// File: rtl/des_pkg.sv
// Shared DES constants: block/half widths, the initial-permutation table and the loader FSM states.
// Table entries use DES numbering: entry n gives the 1-based input bit for output bit n+1, bit 1 = MSB.
package des_pkg;

  localparam int BLK_W  = 64;
  localparam int HALF_W = 32;

  localparam int IP_TABLE [BLK_W] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ld_state_t;

endpackage

// File: rtl/des_ip_perm.sv
// DES initial permutation, purely combinational, zero latency, no flow control.
// DES bit n (1 = MSB) of a vector lives at index BLK_W-n.
module des_ip_perm
  import des_pkg::*;
(
  input  logic [BLK_W-1:0]  i_blk,
  output logic [HALF_W-1:0] o_l,
  output logic [HALF_W-1:0] o_r
);

  logic [BLK_W-1:0] w_perm;

  for (genvar g = 0; g < BLK_W; g++) begin : g_ip
    assign w_perm[BLK_W-1-g] = i_blk[BLK_W-IP_TABLE[g]];
  end

  assign o_l = w_perm[BLK_W-1:HALF_W];
  assign o_r = w_perm[HALF_W-1:0];

endmodule

// File: rtl/des_ip_loader.sv
// Byte-to-block loader with DES IP; block valid the cycle after its 8th byte handshake, IN_READY drops while a
// finished block waits for a busy output register. Optional IN_LAST/OUT_LAST padding via DES_IP_LAST_PAD_EN.
module des_ip_loader
  import des_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        IN_BYTE,
  input  logic              IN_VALID,
  output logic              IN_READY,
`ifdef DES_IP_LAST_PAD_EN
  input  logic              IN_LAST,
  output logic              OUT_LAST,
`endif
  output logic [HALF_W-1:0] L_0,
  output logic [HALF_W-1:0] R_0,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  BLK_COUNT
);

  ld_state_t         r_state;
  logic [2:0]        r_idx;
  logic [BLK_W-1:0]  r_asm;
  logic              r_in_ready;
  logic              r_out_vld;
  logic [HALF_W-1:0] r_l;
  logic [HALF_W-1:0] r_r;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_last;
  logic              w_in_fire;
  logic              w_out_free;
  logic              w_blk_done;
  logic              w_xfer;
  logic [5:0]        w_pos;
  logic [BLK_W-1:0]  w_asm_nxt;
  logic [HALF_W-1:0] w_l;
  logic [HALF_W-1:0] w_r;

`ifdef DES_IP_LAST_PAD_EN
  assign w_in_last = IN_LAST;
`else
  assign w_in_last = 1'b0;
`endif

  assign w_in_fire  = IN_VALID && r_in_ready;
  assign w_out_free = !r_out_vld || OUT_READY;
  assign w_blk_done = w_in_fire && ((r_idx == 3'd7) || w_in_last);
  assign w_xfer     = w_out_free && ((r_state == HOLD) || w_blk_done);

  // Slot s occupies DES bits 8s+1..8s+8; slots after an early IN_LAST are already zero because
  // the assembly register is cleared on every transfer.
  assign w_pos = MSB_FIRST ? {~r_idx, 3'b000} : {r_idx, 3'b000};

  always_comb begin
    w_asm_nxt = r_asm;
    if (w_in_fire) w_asm_nxt[w_pos +: 8] = IN_BYTE;
  end

  // The permutation sees the byte being accepted, so the 8th byte can transfer in its own cycle.
  des_ip_perm u_perm (
    .i_blk (w_asm_nxt),
    .o_l   (w_l),
    .o_r   (w_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_idx      <= '0;
      r_asm      <= '0;
      r_in_ready <= 1'b1;
      r_out_vld  <= 1'b0;
      r_l        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            if (w_blk_done && !w_out_free) begin
              r_asm      <= w_asm_nxt;
              r_state    <= HOLD;
              r_in_ready <= 1'b0;
            end else if (w_blk_done) begin
              r_asm <= '0;
              r_idx <= '0;
            end else begin
              r_asm <= w_asm_nxt;
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (w_out_free) begin
            r_asm      <= '0;
            r_idx      <= '0;
            r_state    <= FILL;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase

      if (w_xfer) begin
        r_out_vld <= 1'b1;
        r_l       <= w_l;
        r_r       <= w_r;
        r_cnt     <= r_cnt + CNT_W'(1);
      end else if (OUT_READY) begin
        r_out_vld <= 1'b0;
      end
    end
  end

`ifdef DES_IP_LAST_PAD_EN
  logic r_hold_last;
  logic r_out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_last <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_blk_done && !w_out_free) r_hold_last <= IN_LAST;
      if (w_xfer) r_out_last <= (r_state == HOLD) ? r_hold_last : IN_LAST;
    end
  end

  assign OUT_LAST = r_out_last;
`endif

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_vld;
  assign L_0       = r_l;
  assign R_0       = r_r;
  assign BLK_COUNT = r_cnt;

endmodule

// File: tb/tb_des_ip_loader.sv
// Bench for des_ip_loader: two instances (MSB-first/16-bit count, LSB-first/3-bit count) share one byte stream;
// a queue-based scoreboard and a byte-level reference model check every presented block.
module tb_des_ip_loader;

`ifdef DES_IP_LAST_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  localparam int IPT [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] cnt;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        ir0, ir1, ov0, ov1, ol0, ol1;
  logic [31:0] l0, r0, l1, r1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_cnt = 0;
  logic [7:0] mb[$];
  exp_t q0[$];
  exp_t q1[$];
  int take_cyc[$];

  des_ip_loader #(.MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .IN_BYTE(in_byte), .IN_VALID(in_valid), .IN_READY(ir0),
`ifdef DES_IP_LAST_PAD_EN
    .IN_LAST(in_last), .OUT_LAST(ol0),
`endif
    .L_0(l0), .R_0(r0), .OUT_VALID(ov0), .OUT_READY(out_ready), .BLK_COUNT(cnt0)
  );

  des_ip_loader #(.MSB_FIRST(1'b0), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .IN_BYTE(in_byte), .IN_VALID(in_valid), .IN_READY(ir1),
`ifdef DES_IP_LAST_PAD_EN
    .IN_LAST(in_last), .OUT_LAST(ol1),
`endif
    .L_0(l1), .R_0(r1), .OUT_VALID(ov1), .OUT_READY(out_ready), .BLK_COUNT(cnt1)
  );

`ifndef DES_IP_LAST_PAD_EN
  assign ol0 = 1'b0;
  assign ol1 = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference IP: output DES bit n takes input DES bit IPT[n-1]; DES bit n is vector index 64-n.
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 1; n <= 64; n++) y[64-n] = x[64-IPT[n-1]];
    return y;
  endfunction

  task automatic model_accept(input logic [7:0] b, input bit last);
    logic [63:0] blk_m, blk_l, p;
    exp_t e;
    mb.push_back(b);
    if (mb.size() == 8 || (last && PAD)) begin
      blk_m = '0;
      blk_l = '0;
      for (int k = 0; k < mb.size(); k++) begin
        blk_m[8*(7-k) +: 8] = mb[k];
        blk_l[8*k +: 8]     = mb[k];
      end
      m_cnt++;
      e.last = last && PAD;
      p = ip(blk_m);
      e.l = p[63:32]; e.r = p[31:0]; e.cnt = 16'(m_cnt);
      q0.push_back(e);
      p = ip(blk_l);
      e.l = p[63:32]; e.r = p[31:0]; e.cnt = 16'(m_cnt % 8);
      q1.push_back(e);
      mb.delete();
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] b, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(negedge clk);
    while (!ir0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: IN_READY stuck low for %0d cycles", n);
    end else begin
      model_accept(b, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    mb.delete();
    q0.delete();
    q1.delete();
    m_cnt = 0;
    idle(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ov0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d0_unexpected: OUT_VALID=1 with L_0=%h, none expected", l0);
        end else begin
          chk("d0_L0", {32'h0, l0}, {32'h0, q0[0].l});
          chk("d0_R0", {32'h0, r0}, {32'h0, q0[0].r});
          chk("d0_cnt", {48'h0, cnt0}, {48'h0, q0[0].cnt});
          if (PAD) chk("d0_last", {63'h0, ol0}, {63'h0, q0[0].last});
          if (out_ready) begin
            void'(q0.pop_front());
            take_cyc.push_back(cyc);
          end
        end
      end
      if (ov1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d1_unexpected: OUT_VALID=1 with L_0=%h, none expected", l1);
        end else begin
          chk("d1_L0", {32'h0, l1}, {32'h0, q1[0].l});
          chk("d1_R0", {32'h0, r1}, {32'h0, q1[0].r});
          chk("d1_cnt", {61'h0, cnt1}, {48'h0, q1[0].cnt});
          if (PAD) chk("d1_last", {63'h0, ol1}, {63'h0, q1[0].last});
          if (out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  logic [7:0] vec [8];
  logic [63:0] pe;
  bit rand_on;

  initial begin
    vec = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    // Reset state
    idle(1);
    do_reset();
    chk("rst_in_ready", {63'h0, ir0}, 64'h1);
    chk("rst_out_valid", {63'h0, ov0}, 64'h0);
    chk("rst_L0R0", {l0, r0}, 64'h0);
    chk("rst_count", {48'h0, cnt0}, 64'h0);
    if (PAD) chk("rst_out_last", {63'h0, ol0}, 64'h0);

    // Known-answer block, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(vec[i], 1'b0);
    chk("kat_valid", {63'h0, ov0}, 64'h1);
    chk("kat_L0", {32'h0, l0}, 64'hCC00CCFF);
    chk("kat_R0", {32'h0, r0}, 64'hF0AAF0AA);
    chk("kat_count", {48'h0, cnt0}, 64'h1);
    idle(1);
    for (int i = 0; i < 8; i++) send(vec[7-i], 1'b0);
    chk("lsb_first_L0", {32'h0, l1}, 64'hCC00CCFF);
    chk("lsb_first_R0", {32'h0, r1}, 64'hF0AAF0AA);
    idle(2);

    // Backpressure into HOLD
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(vec[i], 1'b0);
    for (int i = 0; i < 8; i++) send(8'h00, 1'b0);
    chk("hold_in_ready", {63'h0, ir0}, 64'h0);
    idle(3);
    chk("hold_in_ready_late", {63'h0, ir0}, 64'h0);
    chk("hold_stable", {l0, r0}, 64'hCC00CCFF_F0AAF0AA);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("release_L0R0", {l0, r0}, 64'h0);
    chk("release_valid", {63'h0, ov0}, 64'h1);
    chk("release_in_ready", {63'h0, ir0}, 64'h1);
    chk("release_count", {48'h0, cnt0}, 64'h2);

    // Continuous stream of 4 blocks
    do_reset();
    out_ready = 1'b1;
    take_cyc.delete();
    for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0);
    idle(3);
    chk("stream_blocks", 64'(take_cyc.size()), 64'd4);
    for (int i = 1; i < take_cyc.size(); i++)
      chk("stream_spacing", 64'(take_cyc[i] - take_cyc[i-1]), 64'd8);
    chk("stream_count", {48'h0, cnt0}, 64'h4);

    // Reset mid-block
    do_reset();
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'hFF, 1'b0);
    chk("midrst_L0R0", {l0, r0}, 64'hFFFFFFFF_FFFFFFFF);
    chk("midrst_count", {48'h0, cnt0}, 64'h1);

    // Early IN_LAST padding
    if (PAD) begin
      do_reset();
      out_ready = 1'b1;
      send(8'h01, 1'b0);
      send(8'h23, 1'b0);
      send(8'h45, 1'b1);
      pe = ip(64'h0123450000000000);
      chk("pad_L0R0", {l0, r0}, pe);
      chk("pad_last", {63'h0, ol0}, 64'h1);
      idle(1);
      for (int i = 0; i < 8; i++) send(vec[i], 1'b0);
      chk("pad_next_last", {63'h0, ol0}, 64'h0);
    end

    // Randomized traffic with random backpressure and gaps
    do_reset();
    rand_on = 1'b1;
    fork
      begin
        for (int b = 0; b < 20; b++) begin
          int nb;
          nb = (PAD && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 8;
          for (int i = 0; i < nb; i++) begin
            send(8'($urandom), (i == nb - 1) && (nb < 8 || $urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    begin
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
        idle(1);
        n++;
      end
    end
    idle(2);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("final_count0", {48'h0, cnt0}, 64'(m_cnt));
    chk("final_count1", {61'h0, cnt1}, 64'(m_cnt % 8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
